truth_table_sweeper: RTL and testbench

Controller that drives a 3-input combinational truth-table gate block (in1, in2, in3 -> out) through all 8 input combinations. It waits a programmable settle time per row, samples the gate output and assembles the 8-bit truth-table signature. It compares the signature against an expected hex code and reports match and per-row mismatches. It sits between a test/configuration host and any 3-input gate module in the library, for gate characterisation and built-in self-check.

---
 rtl/truth_table_sweep_pkg.sv | 22 ++
 rtl/settle_timer.sv | 31 +++
 rtl/truth_table_sweeper.sv | 118 +++++++++++
 tb/tb_truth_table_sweeper.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweep_pkg.sv
// Shared types and row/bit mapping for the 3-input truth-table sweeper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package truth_table_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    localparam int TT_ROWS  = 8;
    localparam int TT_IDX_W = 3;
    localparam int TT_W     = 8;

    // Row 000 lands in the MSB so the code reads left-to-right like a printed truth table.
    function automatic logic [TT_IDX_W-1:0] row_bit(input logic [TT_IDX_W-1:0] idx);
        return (TT_IDX_W)'(TT_ROWS - 1) - idx;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Per-row settle counter; expire is high while cnt equals SETTLE_CYCLES-1.
// Latency: expire is combinational from the registered count.
// Backpressure: none; counts only while en is high, clr has priority over load.
module settle_timer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire = (cnt == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a 3-input gate through all 8 rows, captures its truth table and compares to an expected code.
// Latency: done pulses in cycle 8*(SETTLE_CYCLES+1)+1 after the accepted start edge.
// Backpressure: start is ignored while busy; abort drops a sweep in SETTLE/CAPTURE, not in DONE.
module truth_table_sweeper
    import truth_table_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] expected,
    output logic            in1,
    output logic            in2,
    output logic            in3,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] table_out,
    output logic            match,
    output logic [TT_W-1:0] mismatch
);

    state_t                state;
    logic [TT_IDX_W-1:0]   idx;
    logic [TT_W-1:0]       exp_q;
    logic [TT_W-1:0]       tbl_next;
    logic                  timer_clr;
    logic                  timer_expire;

    assign {in1, in2, in3} = idx;

    // Counter restarts from zero on every entry into SETTLE.
    assign timer_clr = (state != SETTLE) || abort;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (timer_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (state == SETTLE),
        .expire   (timer_expire)
    );

    always_comb begin
        tbl_next               = table_out;
        tbl_next[row_bit(idx)] = dut_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            exp_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
            match     <= 1'b0;
            mismatch  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        idx       <= '0;
                        exp_q     <= expected;
                        table_out <= '0;
                        busy      <= 1'b1;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        idx   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (timer_expire) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (abort) begin
                        idx   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        table_out <= tbl_next;
                        if (idx == (TT_IDX_W)'(TT_ROWS - 1)) begin
                            // Compare against the fully captured code, including this last row.
                            done     <= 1'b1;
                            match    <= (tbl_next == exp_q);
                            mismatch <= tbl_next ^ exp_q;
                            state    <= DONE;
                        end else begin
                            idx   <= idx + (TT_IDX_W)'(1);
                            state <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    idx   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Two sweepers (settle 4 and settle 1) against behavioural gate models; results scoreboarded on done.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, abort4, in1_4, in2_4, in3_4, dut_out4, busy4, done4, match4;
    logic [7:0] expected4, table4, mism4;
    logic       start1, abort1, in1_1, in2_1, in3_1, dut_out1, busy1, done1, match1;
    logic [7:0] expected1, table1, mism1;
    logic [1:0] gate_mode;
    logic       d1, d2, e1, e2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] tbl;
        logic       m;
        logic [7:0] mm;
        int         st;
        int         lat;
    } sb_t;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] code;
        logic [7:0] tbl;
        logic       m;
        logic [7:0] mm;
    } vec_t;

    sb_t  sb4[$];
    sb_t  sb1[$];
    vec_t vecs[5];

    always #5 clk = ~clk;

    // Two-flop delayed OR models a slow gate.
    always @(posedge clk) begin
        d1 <= in1_4 | in2_4;
        d2 <= d1;
        e1 <= in1_1 | in2_1;
        e2 <= e1;
    end

    always_comb begin
        case (gate_mode)
            2'd0:    dut_out4 = in1_4 | in2_4;
            2'd1:    dut_out4 = d2;
            2'd2:    dut_out4 = in1_4 & in2_4 & in3_4;
            default: dut_out4 = in1_4 ^ in2_4 ^ in3_4;
        endcase
    end

    assign dut_out1 = e2;

    truth_table_sweeper #(.SETTLE_CYCLES(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort4), .expected(expected4),
        .in1(in1_4), .in2(in2_4), .in3(in3_4), .dut_out(dut_out4), .busy(busy4),
        .done(done4), .table_out(table4), .match(match4), .mismatch(mism4)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .expected(expected1),
        .in1(in1_1), .in2(in2_1), .in3(in3_1), .dut_out(dut_out1), .busy(busy1),
        .done(done1), .table_out(table1), .match(match1), .mismatch(mism1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, req);
        end
    endtask

    // One cycle: advance to the falling edge and score any done pulse.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        cyc++;
        if (done4) begin
            if (sb4.size() == 0) begin
                chk("dut4_unexpected_done", 32'(done4), 32'd0);
            end else begin
                e = sb4.pop_front();
                chk("dut4_table", 32'(table4), 32'(e.tbl));
                chk("dut4_match", 32'(match4), 32'(e.m));
                chk("dut4_mismatch", 32'(mism4), 32'(e.mm));
                chk("dut4_latency", cyc - e.st, e.lat);
                chk("dut4_busy_in_done", 32'(busy4), 32'd1);
            end
        end
        if (done1) begin
            if (sb1.size() == 0) begin
                chk("dut1_unexpected_done", 32'(done1), 32'd0);
            end else begin
                e = sb1.pop_front();
                chk("dut1_table", 32'(table1), 32'(e.tbl));
                chk("dut1_match", 32'(match1), 32'(e.m));
                chk("dut1_mismatch", 32'(mism1), 32'(e.mm));
                chk("dut1_latency", cyc - e.st, e.lat);
            end
        end
    endtask

    task automatic sweep4(input logic [1:0] mode, input logic [7:0] code, input logic [7:0] tbl,
                          input logic mt, input logic [7:0] mm, input int restart_at);
        int  st;
        sb_t e;
        gate_mode = mode;
        tick();
        start4    = 1'b1;
        expected4 = code;
        st        = cyc;
        e.tbl = tbl; e.m = mt; e.mm = mm; e.st = st; e.lat = 41;
        sb4.push_back(e);
        tick();
        start4 = 1'b0;
        chk("dut4_busy_after_start", 32'(busy4), 32'd1);
        chk("dut4_table_cleared", 32'(table4), 32'd0);
        for (int i = 0; i < 60 && sb4.size() != 0; i++) begin
            tick();
            start4    = (restart_at > 0) && (cyc - st == restart_at);
            expected4 = start4 ? 8'h00 : code;
        end
        start4 = 1'b0;
        chk("dut4_done_seen", sb4.size(), 0);
        sb4.delete();
        tick();
        chk("dut4_busy_after_done", 32'(busy4), 32'd0);
        chk("dut4_inputs_idle", 32'({in1_4, in2_4, in3_4}), 32'd0);
    endtask

    initial begin
        int  st;
        sb_t e;

        rst = 1'b1; start4 = 1'b0; abort4 = 1'b0; expected4 = 8'h00;
        start1 = 1'b0; abort1 = 1'b0; expected1 = 8'h00; gate_mode = 2'd0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_done", 32'(done4), 32'd0);
        chk("rst_table", 32'(table4), 32'd0);
        chk("rst_match", 32'(match4), 32'd0);
        chk("rst_mismatch", 32'(mism4), 32'd0);
        chk("rst_inputs", 32'({in1_4, in2_4, in3_4}), 32'd0);
        chk("rst_busy_s1", 32'(busy1), 32'd0);
        rst = 1'b0;

        vecs[0] = '{mode: 2'd0, code: 8'h3F, tbl: 8'h3F, m: 1'b1, mm: 8'h00};
        vecs[1] = '{mode: 2'd0, code: 8'h3E, tbl: 8'h3F, m: 1'b0, mm: 8'h01};
        vecs[2] = '{mode: 2'd2, code: 8'h80, tbl: 8'h01, m: 1'b0, mm: 8'h81};
        vecs[3] = '{mode: 2'd3, code: 8'h69, tbl: 8'h69, m: 1'b1, mm: 8'h00};
        vecs[4] = '{mode: 2'd1, code: 8'h3F, tbl: 8'h3F, m: 1'b1, mm: 8'h00};
        for (int v = 0; v < 5; v++) begin
            sweep4(vecs[v].mode, vecs[v].code, vecs[v].tbl, vecs[v].m, vecs[v].mm, 0);
        end

        // Slow gate with a single settle cycle: each row captures the previous row's output.
        tick();
        start1 = 1'b1; expected1 = 8'h3F; st = cyc;
        e.tbl = 8'h1F; e.m = 1'b0; e.mm = 8'h20; e.st = st; e.lat = 17;
        sb1.push_back(e);
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 40 && sb1.size() != 0; i++) tick();
        chk("dut1_done_seen", sb1.size(), 0);
        sb1.delete();

        // Start re-pulsed mid-sweep with a different code must not disturb the sweep.
        sweep4(2'd0, 8'h3F, 8'h3F, 1'b1, 8'h00, 10);

        // Abort during row 3 settle.
        gate_mode = 2'd0;
        tick();
        start4 = 1'b1; expected4 = 8'h3E; st = cyc;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        abort4 = 1'b1;
        tick();
        abort4 = 1'b0;
        chk("abort_busy", 32'(busy4), 32'd0);
        chk("abort_inputs", 32'({in1_4, in2_4, in3_4}), 32'd0);
        chk("abort_partial_table", 32'(table4), 32'h20);
        chk("abort_match_kept", 32'(match4), 32'd1);
        chk("abort_mismatch_kept", 32'(mism4), 32'h00);
        repeat (45) tick();
        chk("abort_table_held", 32'(table4), 32'h20);

        // Start and abort together in IDLE.
        start4 = 1'b1; abort4 = 1'b1; expected4 = 8'h00;
        tick();
        start4 = 1'b0; abort4 = 1'b0;
        chk("start_abort_busy", 32'(busy4), 32'd0);
        repeat (3) tick();
        chk("start_abort_table", 32'(table4), 32'h20);

        sweep4(2'd0, 8'h3E, 8'h3F, 1'b0, 8'h01, 0);

        // Reset during the capture cycle of row 7.
        tick();
        start4 = 1'b1; expected4 = 8'h3F; st = cyc;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 39; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst7_busy", 32'(busy4), 32'd0);
        chk("rst7_done", 32'(done4), 32'd0);
        chk("rst7_table", 32'(table4), 32'd0);
        chk("rst7_match", 32'(match4), 32'd0);
        chk("rst7_mismatch", 32'(mism4), 32'd0);
        chk("rst7_inputs", 32'({in1_4, in2_4, in3_4}), 32'd0);
        repeat (45) tick();
        chk("rst7_busy_later", 32'(busy4), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
